ram_rd_check: RTL and testbench
===============================

RAM_RD_CHECK -- requirements
Module: ram_rd_check

Interface
REQ-001 Parameter RD_LAT, default 1, meaning RAM read latency in clocks from ram_rd_en/ram_addr to valid ram_rd_data; legal values 1..3.
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 ram_wr_en  input  1  write strobe observed on the 32x8 single-port RAM bus.
REQ-005 ram_rd_en  input  1  read strobe observed on the same bus.
REQ-006 ram_addr  input  5  RAM address.
REQ-007 ram_wr_data  input  8  RAM write data.
REQ-008 ram_rd_data  input  8  RAM read data, valid RD_LAT clocks after its read strobe.
REQ-009 err_flag  output  1  sticky mismatch indicator.
REQ-010 err_cnt  output  16  total mismatches plus protocol errors, saturating.
REQ-011 pass_cnt  output  16  count of error-free frames, saturating.
REQ-012 frame_done  output  1  one-clock pulse at the end of each read phase.
REQ-013 led  output  1  status: 1 = no error since reset; 0 = error seen.

Function
REQ-014 Shadow store: 32 x 8 data registers plus 32 valid bits; on each clock with ram_wr_en=1 and ram_rd_en=0, shadow[ram_addr] <= ram_wr_data and valid[ram_addr] <= 1.
REQ-015 Read pipeline: on each clock with ram_rd_en=1 and ram_wr_en=0, capture {valid[ram_addr], shadow[ram_addr]} into an RD_LAT-deep delay line with a strobe bit.
REQ-016 Compare: when the strobe emerges after RD_LAT clocks, compare ram_rd_data to the expected byte; count a mismatch only if the captured valid bit is 1.
REQ-017 Reads of never-written addresses (valid=0) are neither mismatches nor passes.
REQ-018 A write in the same clock as the expected byte is captured does not affect that read: the capture uses the pre-write shadow value.
REQ-019 Protocol error: ram_wr_en=1 and ram_rd_en=1 in the same clock counts one error, causes no shadow write and no read capture.
REQ-020 FSM states: IDLE, WRITE, READ, DRAIN.
REQ-021 IDLE -> WRITE on ram_wr_en=1; IDLE -> READ on ram_rd_en=1.
REQ-022 WRITE -> READ on ram_rd_en=1; WRITE stays on ram_wr_en=1; WRITE -> IDLE when both strobes are 0.
REQ-023 READ -> DRAIN on the first clock with ram_rd_en=0; READ stays otherwise.
REQ-024 DRAIN waits RD_LAT clocks so that in-flight compares finish, then pulses frame_done for one clock and returns to IDLE.
REQ-025 If ram_wr_en=1 during DRAIN, the write is applied to the shadow immediately; the FSM goes to WRITE after frame_done.
REQ-026 Frame error flag clears on entry to WRITE or READ from IDLE and sets on any mismatch or protocol error in that frame.
REQ-027 On frame_done, increment pass_cnt if the frame error flag is 0.
REQ-028 err_cnt increments by 1 per error event and holds at 16'hFFFF.
REQ-029 pass_cnt holds at 16'hFFFF.
REQ-030 err_flag sets on the first error and is cleared only by reset.
REQ-031 led = ~err_flag, registered.

Reset
REQ-032 rst_n low asynchronously clears the FSM to IDLE, all valid bits, the delay line, and frame error.
REQ-033 During reset, outputs are err_flag=0, err_cnt=0, pass_cnt=0, frame_done=0, led=1.
REQ-034 Shadow data contents need not be cleared.
REQ-035 Reset asserted mid-frame aborts the frame with no frame_done and no pass_cnt change.
REQ-036 After reset, in-flight compares are discarded.

Verification
REQ-037 Write addr 0..31 with data 1..32, then read 0..31, with the RAM model correct and RD_LAT=1 -> err_cnt=0, pass_cnt=1, one frame_done pulse 1 clock after the last read data, led=1.
REQ-038 Same stimulus, but the RAM returns 8'hFF at addr 5 -> err_cnt=1, err_flag=1, led=0, pass_cnt=0.
REQ-039 Read addr 10 with no prior write -> err_cnt=0, frame_done pulses, pass_cnt=1.
REQ-040 ram_wr_en and ram_rd_en both high for one clock in a frame -> err_cnt=1, shadow unchanged, pass_cnt unchanged for that frame.
REQ-041 RD_LAT=3, 32-write/32-read frame -> frame_done 3 clocks after ram_rd_en falls, all 32 compares made, err_cnt=0.
REQ-042 rst_n pulsed low during the read phase at address 16 -> all counters 0, led=1, no frame_done.
REQ-043 Next full good frame after that reset -> pass_cnt=1.

Source files
------------

// File: rtl/ram_rd_check.sv
// Bus monitor for a 32x8 single-port RAM: shadows every write, checks each read's returned data
// after RD_LAT clocks, and keeps per-frame pass / error statistics.
module ram_rd_check #(
    parameter int unsigned RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ram_wr_en,
    input  logic        ram_rd_en,
    input  logic [4:0]  ram_addr,
    input  logic [7:0]  ram_wr_data,
    input  logic [7:0]  ram_rd_data,
    output logic        err_flag,
    output logic [15:0] err_cnt,
    output logic [15:0] pass_cnt,
    output logic        frame_done,
    output logic        led
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StWrite = 2'd1;
    localparam logic [1:0] StRead  = 2'd2;
    localparam logic [1:0] StDrain = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [1:0]  drain_q, drain_d;
    logic        wr_pend_q, wr_pend_d;
    logic        frame_err_q, frame_err_d;
    logic        err_flag_q, err_flag_d;
    logic        led_q;
    logic [15:0] err_cnt_q, err_cnt_d;
    logic [15:0] pass_cnt_q, pass_cnt_d;

    logic [7:0]  shadow_q [32];
    logic [31:0] valid_q;

    logic [RD_LAT-1:0]      pipe_stb_q;
    logic [RD_LAT-1:0]      pipe_vld_q;
    logic [RD_LAT-1:0][7:0] pipe_data_q;

    logic        wr_ok, rd_ok, prot_err, mismatch, err_event, new_frame, pass_inc;
    logic [1:0]  err_inc;
    logic [16:0] err_sum;

    assign prot_err = ram_wr_en & ram_rd_en;
    assign wr_ok    = ram_wr_en & ~ram_rd_en;
    assign rd_ok    = ram_rd_en & ~ram_wr_en;

    // Unwritten addresses are captured with valid=0 and never compared.
    assign mismatch  = pipe_stb_q[RD_LAT-1] & pipe_vld_q[RD_LAT-1] &
                       (pipe_data_q[RD_LAT-1] != ram_rd_data);
    assign err_event = prot_err | mismatch;
    assign err_inc   = {1'b0, prot_err} + {1'b0, mismatch};
    assign err_sum   = {1'b0, err_cnt_q} + {15'd0, err_inc};
    assign err_cnt_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];

    always_comb begin
        state_d    = state_q;
        drain_d    = drain_q;
        wr_pend_d  = wr_pend_q;
        new_frame  = 1'b0;
        frame_done = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (ram_wr_en) begin
                    state_d   = StWrite;
                    new_frame = 1'b1;
                end else if (ram_rd_en) begin
                    state_d   = StRead;
                    new_frame = 1'b1;
                end
            end
            StWrite: begin
                if (ram_rd_en)       state_d = StRead;
                else if (!ram_wr_en) state_d = StIdle;
            end
            StRead: begin
                if (!ram_rd_en) begin
                    state_d   = StDrain;
                    drain_d   = 2'd0;
                    wr_pend_d = 1'b0;
                end
            end
            StDrain: begin
                wr_pend_d = wr_pend_q | ram_wr_en;
                if (drain_q == 2'(RD_LAT - 1)) begin
                    frame_done = 1'b1;
                    wr_pend_d  = 1'b0;
                    if (wr_pend_q || ram_wr_en) begin
                        state_d   = StWrite;
                        new_frame = 1'b1;
                    end else if (ram_rd_en) begin
                        state_d   = StRead;
                        new_frame = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    drain_d = drain_q + 2'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign frame_err_d = new_frame ? err_event : (frame_err_q | err_event);
    // An error landing on the frame_done clock still belongs to the closing frame.
    assign pass_inc    = frame_done & ~frame_err_q & ~err_event;
    assign pass_cnt_d  = (pass_inc && pass_cnt_q != 16'hFFFF) ? pass_cnt_q + 16'd1 : pass_cnt_q;
    assign err_flag_d  = err_flag_q | err_event;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            drain_q     <= 2'd0;
            wr_pend_q   <= 1'b0;
            frame_err_q <= 1'b0;
            err_flag_q  <= 1'b0;
            led_q       <= 1'b1;
            err_cnt_q   <= 16'd0;
            pass_cnt_q  <= 16'd0;
            valid_q     <= 32'd0;
            pipe_stb_q  <= '0;
            pipe_vld_q  <= '0;
            pipe_data_q <= '0;
        end else begin
            state_q     <= state_d;
            drain_q     <= drain_d;
            wr_pend_q   <= wr_pend_d;
            frame_err_q <= frame_err_d;
            err_flag_q  <= err_flag_d;
            led_q       <= ~err_flag_d;
            err_cnt_q   <= err_cnt_d;
            pass_cnt_q  <= pass_cnt_d;
            if (wr_ok) valid_q[ram_addr] <= 1'b1;
            pipe_stb_q[0]  <= rd_ok;
            pipe_vld_q[0]  <= valid_q[ram_addr];
            pipe_data_q[0] <= shadow_q[ram_addr];
            for (int i = 1; i < int'(RD_LAT); i++) begin
                pipe_stb_q[i]  <= pipe_stb_q[i-1];
                pipe_vld_q[i]  <= pipe_vld_q[i-1];
                pipe_data_q[i] <= pipe_data_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) shadow_q[ram_addr] <= ram_wr_data;
    end

    assign err_flag = err_flag_q;
    assign err_cnt  = err_cnt_q;
    assign pass_cnt = pass_cnt_q;
    assign led      = led_q;

endmodule

// File: tb/tb_ram_rd_check.sv
// Scoreboard bench for ram_rd_check: RD_LAT=1 and RD_LAT=3 instances share one bus and a
// behavioural RAM; expected per-frame results are queued and checked on each frame_done.
module tb_ram_rd_check;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_en, rd_en;
    logic [4:0] addr;
    logic [7:0] wr_data;
    logic [7:0] rd_data1, rd_data3, d1, d2, rd_now;
    logic       corrupt;
    logic       done;

    logic        err_flag1, frame_done1, led1, err_flag3, frame_done3, led3;
    logic [15:0] err_cnt1, pass_cnt1, err_cnt3, pass_cnt3;

    always #5 clk = ~clk;

    ram_rd_check #(.RD_LAT(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .ram_wr_en(wr_en), .ram_rd_en(rd_en), .ram_addr(addr),
        .ram_wr_data(wr_data), .ram_rd_data(rd_data1), .err_flag(err_flag1),
        .err_cnt(err_cnt1), .pass_cnt(pass_cnt1), .frame_done(frame_done1), .led(led1)
    );

    ram_rd_check #(.RD_LAT(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .ram_wr_en(wr_en), .ram_rd_en(rd_en), .ram_addr(addr),
        .ram_wr_data(wr_data), .ram_rd_data(rd_data3), .err_flag(err_flag3),
        .err_cnt(err_cnt3), .pass_cnt(pass_cnt3), .frame_done(frame_done3), .led(led3)
    );

    // Behavioural RAM; 'corrupt' makes address 5 read back 8'hFF.
    logic [7:0] mem [32];
    assign rd_now = (corrupt && addr == 5'd5) ? 8'hFF : mem[addr];
    always @(posedge clk) begin
        if (wr_en && !rd_en) mem[addr] <= wr_data;
        rd_data1 <= rd_now;
        d1       <= rd_now;
        d2       <= d1;
        rd_data3 <= d2;
    end

    // Expected frame results: error count and pass count seen during the frame_done cycle,
    // and cycles from the last read strobe to frame_done.
    int sb_err1[$], sb_pass1[$], sb_gap1[$];
    int sb_err3[$], sb_pass3[$], sb_gap3[$];
    string dname_q[$];
    int    dact_q[$], dexp_q[$];

    int checks = 0;
    int errors = 0;
    int since_rd = 0;

    task automatic cmp(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        dname_q.push_back(name);
        dact_q.push_back(act);
        dexp_q.push_back(exp);
    endtask

    // Monitor: sole owner of the counters.
    initial begin
        forever begin
            @(negedge clk);
            if (rd_en) since_rd = 0;
            else       since_rd++;
            while (dname_q.size() > 0)
                cmp(dname_q.pop_front(), dact_q.pop_front(), dexp_q.pop_front());
            if (frame_done1) begin
                if (sb_err1.size() == 0) begin
                    cmp("frame_done1 unexpected pulse", 1, 0);
                end else begin
                    cmp("dut1 err_cnt at frame_done", int'(err_cnt1), sb_err1.pop_front());
                    cmp("dut1 pass_cnt at frame_done", int'(pass_cnt1), sb_pass1.pop_front());
                    cmp("dut1 frame_done delay", since_rd, sb_gap1.pop_front());
                end
            end
            if (frame_done3) begin
                if (sb_err3.size() == 0) begin
                    cmp("frame_done3 unexpected pulse", 1, 0);
                end else begin
                    cmp("dut3 err_cnt at frame_done", int'(err_cnt3), sb_err3.pop_front());
                    cmp("dut3 pass_cnt at frame_done", int'(pass_cnt3), sb_pass3.pop_front());
                    cmp("dut3 frame_done delay", since_rd, sb_gap3.pop_front());
                end
            end
            if (done) begin
                cmp("dut1 missing frame_done", sb_err1.size(), 0);
                cmp("dut3 missing frame_done", sb_err3.size(), 0);
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $finish;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic step(input logic w, input logic r, input logic [4:0] a, input logic [7:0] d);
        wr_en   = w;
        rd_en   = r;
        addr    = a;
        wr_data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 5'd0, 8'd0);
    endtask

    task automatic reset_checks();
        chk("dut1 reset err_flag", int'(err_flag1), 0);
        chk("dut1 reset err_cnt", int'(err_cnt1), 0);
        chk("dut1 reset pass_cnt", int'(pass_cnt1), 0);
        chk("dut1 reset frame_done", int'(frame_done1), 0);
        chk("dut1 reset led", int'(led1), 1);
        chk("dut3 reset err_flag", int'(err_flag3), 0);
        chk("dut3 reset err_cnt", int'(err_cnt3), 0);
        chk("dut3 reset pass_cnt", int'(pass_cnt3), 0);
        chk("dut3 reset frame_done", int'(frame_done3), 0);
        chk("dut3 reset led", int'(led3), 1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        reset_checks();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic expect_frame(input int err, input int pass);
        sb_err1.push_back(err);
        sb_pass1.push_back(pass);
        sb_gap1.push_back(2);
        sb_err3.push_back(err);
        sb_pass3.push_back(pass);
        sb_gap3.push_back(4);
    endtask

    task automatic post(input int err, input int pass, input int flag);
        chk("dut1 err_cnt", int'(err_cnt1), err);
        chk("dut1 pass_cnt", int'(pass_cnt1), pass);
        chk("dut1 err_flag", int'(err_flag1), flag);
        chk("dut1 led", int'(led1), 1 - flag);
        chk("dut3 err_cnt", int'(err_cnt3), err);
        chk("dut3 pass_cnt", int'(pass_cnt3), pass);
        chk("dut3 err_flag", int'(err_flag3), flag);
        chk("dut3 led", int'(led3), 1 - flag);
    endtask

    task automatic full_frame();
        for (int a = 0; a < 32; a++) step(1'b1, 1'b0, 5'(a), 8'(a + 1));
        for (int a = 0; a < 32; a++) step(1'b0, 1'b1, 5'(a), 8'd0);
        idle(8);
    endtask

    initial begin
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        addr    = 5'd0;
        wr_data = 8'd0;
        corrupt = 1'b0;
        done    = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // Good 32-write / 32-read frame.
        expect_frame(0, 0);
        full_frame();
        post(0, 1, 0);

        // RAM returns 8'hFF at address 5.
        do_reset();
        corrupt = 1'b1;
        expect_frame(1, 0);
        full_frame();
        corrupt = 1'b0;
        post(1, 0, 1);

        // Read of a never-written address.
        do_reset();
        expect_frame(0, 0);
        step(1'b0, 1'b1, 5'd10, 8'd0);
        idle(8);
        post(0, 1, 0);

        // Good frame, then a frame with a simultaneous write+read strobe at address 3.
        do_reset();
        expect_frame(0, 0);
        step(1'b1, 1'b0, 5'd3, 8'h33);
        step(1'b0, 1'b1, 5'd3, 8'd0);
        idle(8);
        expect_frame(1, 1);
        step(1'b1, 1'b0, 5'd4, 8'h44);
        step(1'b1, 1'b1, 5'd3, 8'h99);
        step(1'b0, 1'b1, 5'd3, 8'd0);
        idle(8);
        post(1, 1, 1);

        // Reset during the read phase at address 16, then a good frame.
        do_reset();
        for (int a = 0; a < 32; a++) step(1'b1, 1'b0, 5'(a), 8'(a + 1));
        for (int a = 0; a < 16; a++) step(1'b0, 1'b1, 5'(a), 8'd0);
        wr_en = 1'b0;
        rd_en = 1'b1;
        addr  = 5'd16;
        #2;
        rst_n = 1'b0;
        #1;
        reset_checks();
        rd_en = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(8);
        post(0, 0, 0);
        expect_frame(0, 0);
        full_frame();
        post(0, 1, 0);

        idle(2);
        done = 1'b1;
    end

endmodule
